spi_divider: RTL
================

# spi_divider

SPI responder that performs unsigned division for the processor. It sits on the shared `Spi` bus next to the ALU, barrel shifter and multiplier, selected by its own `nss` bit. It receives a `{divisor, dividend, op}` packet from the processor and computes quotient or remainder with a one-bit-per-cycle restoring divider. It then returns the `DataWidth`-bit result using the same start-bit framing the processor expects.

## Interface
- `NssPosition`, default 3: index of this block's select line in `spi.nss`.
- `DataWidth`, default `REGISTER_SIZE` (16): operand/result width.
- `i_clock`  input  1: system clock; `spi.sclk` is this same clock.
- `i_reset`  input  1: reset, asynchronous, active-low.
- `spi`  interface port (`Spi`): reads `nss[NssPosition]` and `mosi`, drives `miso`.

## Operation
- Packet in: `{divisor[W-1:0], dividend[W-1:0], op}`, with W=`DataWidth` and 2W+1 bits, sent LSB first. Bit 0 is `op`: 0 = DIVU (quotient), 1 = REMU (remainder).
- The result is W bits, sent LSB first.
- The block samples `mosi` and `nss` on the rising edge of `i_clock` only.
- `sel` = `~spi.nss[NssPosition]`.
- States:
  - **IDLE**: `miso`=0. If `sel && mosi`=1 at an edge (start bit), go to RX with the bit counter at 0.
  - **RX**: each edge shifts `mosi` into the input register at position counter, then increments the counter. After bit 2W is captured, go to COMPUTE with remainder=0, quotient=dividend and the step counter at 0.
  - **COMPUTE**: one restoring step per cycle, W cycles. Each step:
    - shift `{rem, quo}` left by 1;
    - if `rem >= divisor`, set `rem -= divisor` and `quo[0]=1`.
    - The remainder datapath is W+1 bits wide so the compare never overflows.
    - After step W-1, load the output shift register with `op ? rem : quo` and go to START.
  - **START**: `miso`=1 for exactly one cycle, then go to TX.
  - **TX**: `miso` = `out_shift[0]`. Each edge shifts right. After W bits, go to IDLE.
- Divide by zero (divisor=0): quotient = all ones, remainder = dividend. This result falls out of the restoring algorithm and needs no special case, but it is required behaviour.
- `miso` is 0 in every state except START and TX. It is a function of registered state only (no combinational path from `mosi`/`nss`).
- During the processor's SEND phase `miso` must be 0, because the processor advances only on `~miso && mosi`.
- Abort: if `sel` is 0 at an edge in RX, START or TX, go to IDLE and clear the counters. The next transaction then restarts cleanly. COMPUTE ignores `sel` and completes; START then checks `sel`.
- Reset (asynchronous, at any time including mid-transaction): state=IDLE, all counters and data registers 0, `miso`=0.
- Deselected traffic (another `nss` bit low) is ignored entirely.

## Timing
- Cycle S: start bit, `mosi`=1.
- Cycles S+1 … S+2W+1: input bits 0 … 2W.
- COMPUTE occupies cycles S+2W+2 … S+3W+1.
- START (`miso`=1) is at cycle S+3W+2.
- Result bit k is on `miso` during cycle S+3W+3+k.
- Back to IDLE after cycle S+4W+2. A new start bit is accepted in the following cycle.
- With W=16: 33 bits in, 16 compute, 1 start, 16 out, for 67 cycles from start bit to last result bit.
- The processor's RECEIVE waits indefinitely for `miso`=1, so compute latency is hidden. This block must never assert `miso` before its START state.
- Throughput: one division per 4W+3 cycles. There is no overlap between transactions.

## Test plan
- Dividend 100, divisor 7, op=0 → `miso` start bit at cycle S+50, then 14 (0x000E) LSB first. Same operands with op=1 → 2.
- Dividend 0x1234, divisor 0 → op=0 returns 0xFFFF; op=1 returns 0x1234.
- Dividend 0xFFFF, divisor 1 → quotient 0xFFFF. Dividend 5, divisor 9 → quotient 0, remainder 5.
- Raise `nss[NssPosition]` after 10 input bits, then send a full 100/7 packet → no `miso` activity from the aborted frame, result 14. Repeat the abort during TX: `miso`=0 the cycle after deselect.
- Drive full packets with another `nss` bit selected → `miso` stays 0 throughout and the state stays IDLE. Pulse `i_reset` low mid-COMPUTE → `miso`=0 immediately, and the next 100/7 transaction returns 14.
- Two back-to-back transactions with a start bit on the cycle after the last result bit → both results correct (e.g. 1000/10=100, then 65535/256=255).

Source files
------------

// File: rtl/spi_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_divider_if
// Brief    : Shared processor SPI bus (sclk, per-responder nss, mosi, miso).
// Revision : 1.0 - initial release
// ============================================================================
interface spi_divider_if #(
  parameter int NSS_WIDTH = 4
);
  logic                 sclk;
  logic [NSS_WIDTH-1:0] nss;
  logic                 mosi;
  logic                 miso;

  modport master (output sclk, nss, mosi, input miso);
  modport slave  (input nss, mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/spi_divider.sv
`default_nettype none
// ============================================================================
// Module   : spi_divider
// Brief    : SPI responder computing DIVU/REMU with a restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module spi_divider #(
  parameter int NssPosition = 3,
  parameter int DataWidth   = 16
) (
  input  wire logic       i_clock,
  input  wire logic       i_reset,
  spi_divider_if.slave    spi
);

  localparam int c_cnt_width = $clog2(2 * DataWidth + 1);
  localparam logic [c_cnt_width-1:0] c_last_rx_bit = c_cnt_width'(2 * DataWidth);
  localparam logic [c_cnt_width-1:0] c_last_step   = c_cnt_width'(DataWidth - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX      = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_START   = 3'd3,
    ST_TX      = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [c_cnt_width-1:0]   r_count;
  logic [c_cnt_width-1:0]   w_count_next;
  logic [2*DataWidth:0]     r_packet;
  logic [DataWidth-1:0]     r_rem;
  logic [DataWidth-1:0]     r_quo;
  logic [DataWidth-1:0]     r_out;

  logic                     w_sel;
  logic                     w_op;
  logic [DataWidth-1:0]     w_dividend;
  logic [DataWidth-1:0]     w_divisor;
  logic [DataWidth:0]       w_rem_shift;
  logic [DataWidth-1:0]     w_rem_diff;
  logic                     w_fits;
  logic [DataWidth-1:0]     w_rem_next;
  logic [DataWidth-1:0]     w_quo_next;

  assign w_sel      = ~spi.nss[NssPosition];
  assign w_op       = r_packet[0];
  assign w_dividend = r_packet[DataWidth:1];
  assign w_divisor  = r_packet[2*DataWidth:DataWidth+1];

  // Compare is W+1 bits wide; the difference only matters when it fits, so W bits suffice.
  assign w_rem_shift = {r_rem, r_quo[DataWidth-1]};
  assign w_fits      = w_rem_shift >= {1'b0, w_divisor};
  assign w_rem_diff  = w_rem_shift[DataWidth-1:0] - w_divisor;
  assign w_rem_next  = w_fits ? w_rem_diff : w_rem_shift[DataWidth-1:0];
  assign w_quo_next  = {r_quo[DataWidth-2:0], w_fits};

  assign spi.miso = (r_state == ST_START) || ((r_state == ST_TX) && r_out[0]);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      ST_IDLE: begin
        w_count_next = '0;
        if (w_sel && spi.mosi) w_state_next = ST_RX;
      end
      ST_RX: begin
        if (!w_sel) begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
        end else if (r_count == c_last_rx_bit) begin
          w_state_next = ST_COMPUTE;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      ST_COMPUTE: begin
        if (r_count == c_last_step) begin
          w_state_next = ST_START;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      ST_START: begin
        w_count_next = '0;
        w_state_next = w_sel ? ST_TX : ST_IDLE;
      end
      ST_TX: begin
        if (!w_sel || (r_count == c_last_step)) begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_packet <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_out    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel && spi.mosi) r_packet <= '0;
        end
        ST_RX: begin
          if (w_sel) begin
            r_packet[r_count] <= spi.mosi;
            // Dividend bits are already complete when the last divisor bit arrives.
            if (r_count == c_last_rx_bit) begin
              r_rem <= '0;
              r_quo <= w_dividend;
            end
          end
        end
        ST_COMPUTE: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_count == c_last_step) r_out <= w_op ? w_rem_next : w_quo_next;
        end
        ST_TX: begin
          if (w_sel) r_out <= r_out >> 1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
